// File: rtl/ram.sv
// Single-write / single-async-read register-file RAM with synchronous active-low clear.
// Optional RAM_BYPASS_EN: forwards wdata to rdata on a same-cycle write/read address match.
module ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              w,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned CMP_W = ADDR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic              waddr_ok;
   logic              raddr_ok;
   logic [DATA_W-1:0] rdata_mem;

   // Range checks keep non-power-of-two depths from aliasing into real words.
   always_comb begin
      waddr_ok = ({1'b0, waddr} < CMP_W'(DEPTH));
      raddr_ok = ({1'b0, raddr} < CMP_W'(DEPTH));
   end

   always_comb begin
      mem_d = mem_q;
      if (w && waddr_ok) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      rdata_mem = '0;
      if (raddr_ok) begin
         rdata_mem = mem_q[raddr];
      end
   end

`ifdef RAM_BYPASS_EN
   always_comb begin
      rdata = rdata_mem;
      if (w && rst_n && (raddr == waddr)) begin
         rdata = wdata;
      end
   end
`else
   always_comb begin
      rdata = rdata_mem;
   end
`endif

endmodule

// File: tb/tb_ram.sv
// Directed self-checking bench for ram; RAM_BYPASS_EN selects the collision expectation.
module tb_ram;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DEPTH  = 32;

   logic              clk;
   logic              rst_n;
   logic              w;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] raddr;
   logic [DATA_W-1:0] rdata;

   int checks;
   int errors;

   ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .w     (w),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      w     = 1'b0;
      waddr = '0;
      wdata = '0;
      raddr = '0;
      step();
      step();
      rst_n = 1'b1;
      for (int a = 0; a < 32; a++) begin
         raddr = ADDR_W'(a);
         #1;
         checks++;
         if (rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_clear addr=%0d got=%h exp=00", a, rdata);
         end
      end
   endtask

   task automatic test_write_read();
      w = 1'b1; waddr = 5'd0; wdata = 8'd10; step();
      waddr = 5'd1; wdata = 8'd20; step();
      waddr = 5'd2; wdata = 8'd30; step();
      w = 1'b0;
      for (int a = 0; a < 4; a++) begin
         logic [7:0] exp;
         exp = (a == 0) ? 8'd10 : (a == 1) ? 8'd20 : (a == 2) ? 8'd30 : 8'd0;
         raddr = ADDR_W'(a);
         #1;
         checks++;
         if (rdata !== exp) begin
            errors++;
            $display("FAIL write_read addr=%0d got=%0d exp=%0d", a, rdata, exp);
         end
      end
   endtask

   task automatic test_read_hold();
      raddr = 5'd0;
      w = 1'b1; waddr = 5'd1; wdata = 8'h11;
      #1;
      checks++;
      if (rdata !== 8'd10) begin
         errors++; $display("FAIL read_hold_a got=%0d exp=10", rdata);
      end
      step();
      waddr = 5'd2; wdata = 8'h22;
      #1;
      checks++;
      if (rdata !== 8'd10) begin
         errors++; $display("FAIL read_hold_b got=%0d exp=10", rdata);
      end
      step();
      w = 1'b0;
      #1;
      checks++;
      if (rdata !== 8'd10) begin
         errors++; $display("FAIL read_hold_c got=%0d exp=10", rdata);
      end
      raddr = 5'd1; #1;
      checks++;
      if (rdata !== 8'h11) begin
         errors++; $display("FAIL read_hold_new1 got=%h exp=11", rdata);
      end
      raddr = 5'd2; #1;
      checks++;
      if (rdata !== 8'h22) begin
         errors++; $display("FAIL read_hold_new2 got=%h exp=22", rdata);
      end
   endtask

   task automatic test_back_to_back();
      raddr = 5'd0;
      w = 1'b1; waddr = 5'd31; wdata = 8'hA5; step();
      wdata = 8'h5A; step();
      w = 1'b0;
      raddr = 5'd31; #1;
      checks++;
      if (rdata !== 8'h5A) begin
         errors++; $display("FAIL b2b_last_wins got=%h exp=5a", rdata);
      end
      raddr = 5'd0; #1;
      checks++;
      if (rdata !== 8'd10) begin
         errors++; $display("FAIL b2b_addr0 got=%0d exp=10", rdata);
      end
      // w=0 with live address/data must leave memory alone
      waddr = 5'd5; wdata = 8'h77; step();
      raddr = 5'd5; #1;
      checks++;
      if (rdata !== 8'h00) begin
         errors++; $display("FAIL write_disabled got=%h exp=00", rdata);
      end
   endtask

   task automatic test_collision();
      w = 1'b1; waddr = 5'd7; wdata = 8'h3C; raddr = 5'd7;
      #1;
      checks++;
`ifdef RAM_BYPASS_EN
      if (rdata !== 8'h3C) begin
         errors++; $display("FAIL collision_before got=%h exp=3c", rdata);
      end
`else
      if (rdata !== 8'h00) begin
         errors++; $display("FAIL collision_before got=%h exp=00", rdata);
      end
`endif
      step();
      w = 1'b0;
      #1;
      checks++;
      if (rdata !== 8'h3C) begin
         errors++; $display("FAIL collision_after got=%h exp=3c", rdata);
      end
      // non-colliding read during a write keeps stored data
      w = 1'b1; waddr = 5'd8; wdata = 8'h99; raddr = 5'd7;
      #1;
      checks++;
      if (rdata !== 8'h3C) begin
         errors++; $display("FAIL noncollide got=%h exp=3c", rdata);
      end
      step();
      w = 1'b0; raddr = 5'd8; #1;
      checks++;
      if (rdata !== 8'h99) begin
         errors++; $display("FAIL noncollide_written got=%h exp=99", rdata);
      end
   endtask

   task automatic test_reset_priority();
      rst_n = 1'b0; w = 1'b1; waddr = 5'd4; wdata = 8'hFF;
      step();
      rst_n = 1'b1; w = 1'b0;
      for (int a = 0; a < 32; a++) begin
         raddr = ADDR_W'(a);
         #1;
         checks++;
         if (rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_priority addr=%0d got=%h exp=00", a, rdata);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_write_read();
      test_read_hold();
      test_back_to_back();
      test_collision();
      test_reset_priority();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram.md
RAM -- requirements
Module: ram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 32 (2**ADDR_W), giving the number of words.
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  SHALL be the reset; synchronous, active-low.
REQ-006 Port w  input  1  SHALL be the write enable, active-high.
REQ-007 Port waddr  input  ADDR_W  SHALL be the write address.
REQ-008 Port wdata  input  DATA_W  SHALL be the write data.
REQ-009 Port raddr  input  ADDR_W  SHALL be the read address.
REQ-010 Port rdata  output  DATA_W  SHALL be the read data.

Function
REQ-011 Storage SHALL be DEPTH words of DATA_W bits, one independent write port and one independent read port.
REQ-012 Write: on a rising clk edge with rst_n=1 and w=1, mem[waddr] SHALL take wdata; with w=0, memory SHALL be unchanged.
REQ-013 Read SHALL be asynchronous: rdata = mem[raddr] combinationally, zero clock latency; a change of raddr SHALL change rdata in the same cycle.
REQ-014 Written data SHALL be readable from the cycle after the write edge and SHALL persist until overwritten or reset.
REQ-015 Write with w=1 SHALL complete every cycle; back-to-back writes to consecutive or identical addresses SHALL all take effect, the last write winning.
REQ-016 Addresses SHALL cover 0..DEPTH-1 exactly; when DEPTH < 2**ADDR_W, writes to out-of-range addresses SHALL be ignored and out-of-range reads SHALL return 0.
REQ-017 Unknown (X/Z) address or enable inputs are outside the operating envelope; no behaviour is required for them.

Reset
REQ-018 On a rising clk edge with rst_n=0, every memory word SHALL be cleared to 0.
REQ-019 A write asserted in the same cycle as reset SHALL be discarded; reset has priority.
REQ-020 rdata SHALL read 0 for every address from the first cycle after a reset edge until that address is written.
REQ-021 Reset asserted mid-sequence SHALL erase all prior writes; no partial contents SHALL survive.

Configuration
REQ-022 Macro RAM_BYPASS_EN, when defined, SHALL enable write-to-read forwarding: when w=1, rst_n=1 and raddr==waddr, rdata SHALL equal wdata combinationally in that cycle.
REQ-023 Without RAM_BYPASS_EN, rdata SHALL show the pre-write contents of mem[raddr] during the write cycle and the new value only after the write edge.
REQ-024 RAM_BYPASS_EN SHALL NOT alter write, reset or any non-colliding read behaviour.

Verification
REQ-025 Reset, then write 10@0, 20@1, 30@2 on successive edges, then w=0 and raddr=0,1,2,3 -> rdata 10, 20, 30, 0.
REQ-026 Keep raddr=0 while writing addresses 1 and 2 -> rdata stays 10 throughout.
REQ-027 Write 0xA5@31, then 0x5A@31 on the next edge, then read 31 -> rdata 0x5A; read 0 -> rdata unchanged.
REQ-028 After writes, hold rst_n=0 for one edge while w=1, waddr=4, wdata=0xFF -> all addresses including 4 read 0.
REQ-029 Write 0x3C@7 with raddr=7 in the same cycle (old value 0) -> rdata 0x3C before the edge with RAM_BYPASS_EN, 0 before / 0x3C after the edge without it.
